// File: rtl/ecc_bch15_pkg.sv
// BCH(15,10) code geometry, H-matrix columns {s4..s0} and FSM state type.
// Shared by the serial receiver and the matching encoder.
package ecc_bch15_pkg;

    localparam int N = 15;
    localparam int K = 10;
    localparam int R = 5;

    localparam logic [3:0] LOC_NONE = 4'hF;

    // Data columns 0..9 followed by the identity parity columns 10..14.
    localparam logic [R-1:0] COL [0:N-1] = '{
        5'b10101, 5'b11111, 5'b01011, 5'b10110, 5'b11001,
        5'b00111, 5'b01110, 5'b11100, 5'b01101, 5'b11010,
        5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000
    };

    typedef enum logic {
        ST_HUNT  = 1'b0,
        ST_SHIFT = 1'b1
    } rx_state_t;

endpackage

// File: rtl/ecc_bch15_syn_lut.sv
// Combinational BCH(15,10) helpers: bit index to H column, and syndrome to
// {location, correctable, uncorrectable} classification.
module ecc_bch15_syn_lut
    import ecc_bch15_pkg::*;
(
    input  logic [3:0]   i_bit_idx,
    input  logic [R-1:0] i_syn,
    output logic [R-1:0] o_col,
    output logic [3:0]   o_loc,
    output logic         o_correct,
    output logic         o_uncorrect
);

    always_comb begin
        o_col       = '0;
        o_loc       = LOC_NONE;
        o_correct   = 1'b0;
        o_uncorrect = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (i_bit_idx == 4'(i)) o_col = COL[i];
            if (i_syn == COL[i]) begin
                o_loc     = 4'(i);
                o_correct = 1'b1;
            end
        end
        // Non-zero syndrome matching no column: at least two bits in error.
        if ((i_syn != '0) && !o_correct) o_uncorrect = 1'b1;
    end

endmodule

// File: rtl/ecc_15to10_serial_rx.sv
// Bit-serial BCH(15,10) receiver: on-the-fly syndrome, single-error correction.
// Define ECC_RX_ERR_CNT_EN to add saturating corrected/uncorrectable counters.
module ecc_15to10_serial_rx
    import ecc_bch15_pkg::*;
`ifdef ECC_RX_ERR_CNT_EN
#(
    parameter int CNT_W = 16
)
`endif
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_bit,
    input  logic         in_sof,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [K-1:0] out_data,
    output logic         out_err_correct,
    output logic         out_err_uncorrect,
    output logic [3:0]   out_err_loc,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         frame_err
`ifdef ECC_RX_ERR_CNT_EN
    ,
    output logic [CNT_W-1:0] cnt_corr,
    output logic [CNT_W-1:0] cnt_uncorr
`endif
);

    rx_state_t    r_state;
    logic [3:0]   r_bit_idx;
    logic [R-1:0] r_syn;
    // Parity bits only feed the syndrome, so only data positions are kept.
    logic [K-1:0] r_buf;
    logic [K-1:0] r_out_data;
    logic         r_out_corr;
    logic         r_out_uncorr;
    logic [3:0]   r_out_loc;
    logic         r_out_valid;
    logic         r_frame_err;

    logic         w_accept;
    logic         w_last;
    logic [3:0]   w_idx;
    logic [R-1:0] w_col;
    logic [R-1:0] w_syn_next;
    logic [3:0]   w_loc;
    logic         w_correct;
    logic         w_uncorrect;
    logic [K-1:0] w_flip;

    assign in_ready = !((r_bit_idx == 4'(N-1)) && r_out_valid && !out_ready);
    assign w_accept = in_valid && in_ready;
    assign w_idx    = in_sof ? 4'd0 : r_bit_idx;
    assign w_last   = w_accept && (r_state == ST_SHIFT) && !in_sof
                      && (r_bit_idx == 4'(N-1));
    assign w_syn_next = ((w_idx == 4'd0) ? '0 : r_syn) ^ (w_col & {R{in_bit}});

    ecc_bch15_syn_lut u_lut (
        .i_bit_idx   (w_idx),
        .i_syn       (w_syn_next),
        .o_col       (w_col),
        .o_loc       (w_loc),
        .o_correct   (w_correct),
        .o_uncorrect (w_uncorrect)
    );

    always_comb begin
        w_flip = '0;
        for (int i = 0; i < K; i++) begin
            w_flip[i] = w_correct && (w_loc == 4'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_HUNT;
            r_bit_idx    <= 4'd0;
            r_syn        <= '0;
            r_buf        <= '0;
            r_out_data   <= '0;
            r_out_corr   <= 1'b0;
            r_out_uncorr <= 1'b0;
            r_out_loc    <= LOC_NONE;
            r_out_valid  <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            if (r_out_valid && out_ready) r_out_valid <= 1'b0;
            if (w_accept) begin
                if (in_sof) begin
                    r_state   <= ST_SHIFT;
                    r_bit_idx <= 4'd1;
                    r_syn     <= w_syn_next;
                    r_buf[0]  <= in_bit;
                    if (r_bit_idx != 4'd0) r_frame_err <= 1'b1;
                end else if (r_state == ST_SHIFT) begin
                    r_syn <= w_syn_next;
                    if (r_bit_idx < 4'(K)) r_buf[r_bit_idx] <= in_bit;
                    if (w_last) begin
                        r_bit_idx    <= 4'd0;
                        r_out_data   <= r_buf ^ w_flip;
                        r_out_corr   <= w_correct;
                        r_out_uncorr <= w_uncorrect;
                        r_out_loc    <= w_loc;
                        r_out_valid  <= 1'b1;
                    end else begin
                        r_bit_idx <= r_bit_idx + 4'd1;
                    end
                end
            end
        end
    end

`ifdef ECC_RX_ERR_CNT_EN
    logic [CNT_W-1:0] r_cnt_corr;
    logic [CNT_W-1:0] r_cnt_uncorr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_corr   <= '0;
            r_cnt_uncorr <= '0;
        end else if (w_last) begin
            if (w_correct && (r_cnt_corr != '1))     r_cnt_corr   <= r_cnt_corr + CNT_W'(1);
            if (w_uncorrect && (r_cnt_uncorr != '1)) r_cnt_uncorr <= r_cnt_uncorr + CNT_W'(1);
        end
    end

    assign cnt_corr   = r_cnt_corr;
    assign cnt_uncorr = r_cnt_uncorr;
`endif

    assign out_data          = r_out_data;
    assign out_err_correct   = r_out_corr;
    assign out_err_uncorrect = r_out_uncorr;
    assign out_err_loc       = r_out_loc;
    assign out_valid         = r_out_valid;
    assign frame_err         = r_frame_err;

endmodule
